l2_traffic_gen: RTL and testbench

//  Synthesizable, parametrised L2 request stimulus engine plus cmd_req/cmd_ack responder for dram_ctrl bring-up.

---
 rtl/l2_traffic_gen.sv | 174 +++++++++++++++++
 tb/tb_l2_traffic_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_traffic_gen.sv
// L2 request stimulus engine: LFSR write fill, descending read-back,
// plus a delayed 4-phase cmd_req/cmd_ack responder.
module l2_traffic_gen #(
  parameter int L2_REQ_WIDTH = 20,
  parameter int DATA_WIDTH   = 8,
  parameter int CNT_WIDTH    = 8,
  parameter int ACK_DELAY    = 2
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [L2_REQ_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]    num_req,
  input  logic [15:0]             seed,
  input  logic                    req_ready,
  output logic                    l2_req_valid,
  output logic                    l2_rw_req,
  output logic [L2_REQ_WIDTH-1:0] l2_req_instr,
  output logic [DATA_WIDTH-1:0]   l2_req_data,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    req_count,
  input  logic                    cmd_req,
  output logic                    cmd_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam int AW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  state_t                  state_q, state_d;
  logic [L2_REQ_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]    num_q, num_d;
  logic [1:0]              mode_q, mode_d;
  logic                    ack_q, ack_d;
  logic [AW-1:0]           ackc_q, ackc_d;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic                    last;

  // x^16+x^14+x^13+x^11+1, shift left with feedback into bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lfsr_q  <= LFSR_INIT;
      cnt_q   <= '0;
      num_q   <= '0;
      mode_q  <= '0;
      ack_q   <= 1'b0;
      ackc_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      mode_q  <= mode_d;
      ack_q   <= ack_d;
      ackc_q  <= ackc_d;
    end
  end

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);
  assign last    = (cnt_inc == num_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d = (seed == 16'h0) ? LFSR_INIT : seed;
          cnt_d  = '0;
          mode_d = mode;
          num_d  = num_req;
          if (num_req == '0) begin
            state_d = S_DONE;
          end else if (mode == 2'd1) begin
            state_d = S_READ;
            addr_d  = base_addr + L2_REQ_WIDTH'(num_req)
                      - L2_REQ_WIDTH'(1);
          end else begin
            state_d = S_WRITE;
            addr_d  = base_addr;
          end
        end
      end
      S_WRITE: begin
        if (req_ready) begin
          lfsr_d = lfsr_step(lfsr_q);
          cnt_d  = cnt_inc;
          addr_d = addr_q + L2_REQ_WIDTH'(1);
          if (last) begin
            if (mode_q == 2'd0) begin
              state_d = S_DONE;
            end else begin
              // read-back starts at the last written address
              state_d = S_READ;
              addr_d  = addr_q;
              cnt_d   = '0;
            end
          end
        end
      end
      S_READ: begin
        if (req_ready) begin
          addr_d = addr_q - L2_REQ_WIDTH'(1);
          cnt_d  = cnt_inc;
          if (last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // a cmd_req change that reverts before the delay expires is dropped
  always_comb begin
    ack_d  = ack_q;
    ackc_d = '0;
    if (cmd_req != ack_q) begin
      if (ackc_q == AW'(ACK_DELAY - 1)) begin
        ack_d  = cmd_req;
        ackc_d = '0;
      end else begin
        ackc_d = ackc_q + AW'(1);
      end
    end
  end

  always_comb begin
    l2_req_valid = 1'b0;
    l2_rw_req    = 1'b0;
    l2_req_instr = '0;
    l2_req_data  = '0;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    unique case (1'b1)
      (state_q == S_WRITE): begin
        l2_req_valid = 1'b1;
        l2_rw_req    = 1'b1;
        l2_req_instr = addr_q;
        l2_req_data  = lfsr_q[DATA_WIDTH-1:0];
      end
      (state_q == S_READ): begin
        l2_req_valid = 1'b1;
        l2_req_instr = addr_q;
      end
      (state_q == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

  assign req_count = cnt_q;
  assign cmd_ack   = ack_q;

endmodule

// File: tb/tb_l2_traffic_gen.sv
// Self-checking bench for l2_traffic_gen: transaction-queue model
// for the request engine and a run-length model for the ack responder.
module tb_l2_traffic_gen;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AD = 2;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_req;
  logic [15:0]   seed;
  logic          req_ready;
  logic          l2_req_valid;
  logic          l2_rw_req;
  logic [AW-1:0] l2_req_instr;
  logic [DW-1:0] l2_req_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] req_count;
  logic          cmd_req;
  logic          cmd_ack;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t expq[$];

  always #5 clk = ~clk;

  l2_traffic_gen #(
    .L2_REQ_WIDTH(AW),
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .ACK_DELAY   (AD)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .mode        (mode),
    .base_addr   (base_addr),
    .num_req     (num_req),
    .seed        (seed),
    .req_ready   (req_ready),
    .l2_req_valid(l2_req_valid),
    .l2_rw_req   (l2_rw_req),
    .l2_req_instr(l2_req_instr),
    .l2_req_data (l2_req_data),
    .busy        (busy),
    .done        (done),
    .req_count   (req_count),
    .cmd_req     (cmd_req),
    .cmd_ack     (cmd_ack)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic fb;
    fb = x[15] ^ x[13] ^ x[12] ^ x[10];
    return {x[14:0], fb};
  endfunction

  // Expected transaction list for one sequence
  task automatic build(input logic [1:0] m, input logic [AW-1:0] b,
                       input logic [CW-1:0] n, input logic [15:0] s);
    logic [15:0]   lf;
    logic [AW-1:0] a;
    txn_t          t;
    expq.delete();
    lf = (s == 16'h0) ? 16'hACE1 : s;
    if (m != 2'd1) begin
      for (int i = 0; i < int'(n); i++) begin
        a = b + AW'(i);
        t.rw = 1'b1; t.addr = a; t.data = lf[DW-1:0];
        expq.push_back(t);
        lf = lfsr_next(lf);
      end
    end
    if (m != 2'd0) begin
      for (int i = 0; i < int'(n); i++) begin
        a = b + AW'(int'(n) - 1 - i);
        t.rw = 1'b0; t.addr = a; t.data = '0;
        expq.push_back(t);
      end
    end
  endtask

  // rmode: 0 always ready, 1 random, 2 low for 5 cycles mid-sequence
  task automatic run_seq(input logic [1:0] m, input logic [AW-1:0] b,
                         input logic [CW-1:0] n, input logic [15:0] s,
                         input int rmode, input bit spam);
    int total, popped, cyc;
    bit fin;
    txn_t t;
    logic [CW-1:0] ecnt;
    build(m, b, n, s);
    total = expq.size();
    @(negedge clk);
    start = 1'b1; mode = m; base_addr = b; num_req = n; seed = s;
    req_ready = 1'b0;
    @(negedge clk);
    if (!spam) start = 1'b0;
    popped = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (popped == total) begin
        checks++;
        if ({l2_req_valid, done, busy, req_count} !== {2'b01, 1'b1, n}) begin
          failures++;
          $display("FAIL done_state got v=%b d=%b b=%b cnt=%0d exp v=0 d=1 b=1 cnt=%0d",
                   l2_req_valid, done, busy, req_count, n);
        end
        start = 1'b0;
        req_ready = 1'b0;
        fin = 1'b1;
      end else begin
        t = expq[popped];
        ecnt = (m >= 2'd2 && popped >= int'(n)) ? CW'(popped - int'(n)) : CW'(popped);
        checks++;
        if ({l2_req_valid, done, busy, l2_rw_req, l2_req_instr, l2_req_data}
            !== {3'b101, t.rw, t.addr, t.data}) begin
          failures++;
          $display("FAIL req_fields idx=%0d got v=%b d=%b rw=%b a=%h dat=%h exp rw=%b a=%h dat=%h",
                   popped, l2_req_valid, done, l2_rw_req, l2_req_instr, l2_req_data,
                   t.rw, t.addr, t.data);
        end
        checks++;
        if (req_count !== ecnt) begin
          failures++;
          $display("FAIL req_count idx=%0d got=%0d exp=%0d", popped, req_count, ecnt);
        end
        case (rmode)
          0: req_ready = 1'b1;
          1: req_ready = ($urandom % 4) != 0;
          default: req_ready = !(cyc >= 2 && cyc < 7);
        endcase
        if (spam) begin
          start = 1'b1; mode = 2'($urandom); base_addr = AW'($urandom);
          num_req = CW'($urandom); seed = 16'($urandom);
        end
        if (req_ready) popped++;
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) begin
      failures++;
      $display("FAIL seq_timeout got popped=%0d exp=%0d", popped, total);
      start = 1'b0;
      req_ready = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({busy, done, l2_req_valid} !== 3'b000) begin
      failures++;
      $display("FAIL back_to_idle got b=%b d=%b v=%b exp 000", busy, done, l2_req_valid);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({l2_req_valid, l2_rw_req, l2_req_instr, l2_req_data,
         busy, done, req_count, cmd_ack} !== '0) begin
      failures++;
      $display("FAIL %s got v=%b rw=%b a=%h d=%h b=%b dn=%b c=%0d ack=%b exp all 0",
               nm, l2_req_valid, l2_rw_req, l2_req_instr, l2_req_data,
               busy, done, req_count, cmd_ack);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_state");
    end
    rst_b = 1'b0;
  endtask

  task automatic test_write_wrap();
    run_seq(2'd0, 20'hFFFFE, 8'd4, 16'h1234, 0, 1'b0);
  endtask

  task automatic test_write_read();
    run_seq(2'd2, 20'h00100, 8'd3, 16'h0001, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_seq(2'd2, 20'h00040, 8'd8, 16'hBEEF, 2, 1'b0);
  endtask

  task automatic test_zero_and_ignore();
    run_seq(2'd0, 20'h00005, 8'd0, 16'h5555, 0, 1'b0);
    run_seq(2'd3, 20'hABCDE, 8'd6, 16'h0F0F, 1, 1'b1);
  endtask

  task automatic test_seed_zero_read_only();
    run_seq(2'd0, 20'h00000, 8'd3, 16'h0000, 0, 1'b0);
    run_seq(2'd1, 20'hFFFFD, 8'd5, 16'h7777, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      run_seq(2'($urandom), AW'($urandom), CW'($urandom_range(0, 12)),
              (k % 5 == 0) ? 16'h0 : 16'($urandom), 1, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; mode = 2'd0; base_addr = 20'h00010; num_req = 8'd20;
    seed = 16'h2222; req_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (l2_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_active got v=%b exp 1", l2_req_valid);
    end
    rst_b = 1'b1;
    @(negedge clk);
    check_zero("reset_mid");
    rst_b = 1'b0;
    req_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("after_reset_mid");
    end
  endtask

  task automatic test_ack();
    logic pat [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    logic exp_ack;
    int   run;
    logic v;
    exp_ack = 1'b0;
    run = 0;
    for (int i = 0; i < 92; i++) begin
      if (i < 12) v = pat[i];
      else if ($urandom % 3 == 0) v = ~cmd_req;
      else v = cmd_req;
      cmd_req = v;
      if (v != exp_ack) begin
        run++;
        if (run == AD) begin
          exp_ack = v;
          run = 0;
        end
      end else begin
        run = 0;
      end
      @(negedge clk);
      checks++;
      if (cmd_ack !== exp_ack) begin
        failures++;
        $display("FAIL cmd_ack step=%0d got=%b exp=%b", i, cmd_ack, exp_ack);
      end
    end
    cmd_req = 1'b0;
  endtask

  initial begin
    rst_b = 1'b1; start = 1'b0; mode = '0; base_addr = '0;
    num_req = '0; seed = '0; req_ready = 1'b0; cmd_req = 1'b0;
    test_reset();
    test_write_wrap();
    test_write_read();
    test_stall();
    test_zero_and_ignore();
    test_seed_zero_read_only();
    test_random();
    test_reset_mid();
    test_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
